pipe_sequencer: RTL
===================

Name: pipe_sequencer

Overview:
Cycle-level sequencer for the 3-stage (FD / X / MW) RV32 core. It drives per-stage advance and flush controls, owns the data-memory request handshake from the X stage, and stretches the pipeline on memory back-pressure. It also sequences post-reset boot and an external halt/drain, and reports a memory-timeout error. It sits beside the combinational decode/forwarding control and overrides its stage enables.

Parameters:
BOOT_CYCLES, 4, cycles after reset release before the first fetch (>=1)
TIMEOUT, 64, max cycles waiting for dmem_gnt before error (>=2)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
x_valid  in  1  X stage holds a real (non-bubble) instruction
x_mem  in  1  X instruction is a load or store
x_redirect  in  1  X is taken branch or JALR (PC must jump)
mw_valid  in  1  MW stage holds a real instruction
dmem_gnt  in  1  data memory accepts request this cycle
halt_req  in  1  level request to stop fetching and drain
pc_en  out  1  PC register may update
fd_en  out  1  FD stage may capture
x_en  out  1  X stage may capture from FD
mw_en  out  1  MW stage may capture from X
x_flush  out  1  X captures a NOP instead of FD contents
mw_flush  out  1  MW captures a NOP instead of X contents
dmem_req  out  1  data memory request for X instruction
boot_done  out  1  high once BOOT complete
halted  out  1  pipeline drained and stopped
err  out  1  sticky dmem timeout
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset is async on rst_n low. State=BOOT, all *_en=0, x_flush=mw_flush=1, dmem_req=0, boot_done=halted=err=0, stall_cnt=0, boot counter=BOOT_CYCLES-1, wait counter=0.
- States: BOOT, RUN, MEM_WAIT, DRAIN, HALT, ERR. Outputs are combinational from state and inputs. Counters and state are registered.
- BOOT:
  - Enables 0, flushes 1; counter decrements each cycle.
  - At 0 -> RUN. boot_done is registered high on entry to RUN and stays high until reset.
- RUN, default: all *_en=1, flushes 0.
  - dmem_req = x_valid & x_mem.
  - If dmem_req & !dmem_gnt: pc_en=fd_en=x_en=0, mw_en=1 with mw_flush=1 (bubble into MW). Go to MEM_WAIT; wait counter=1.
  - If x_redirect & x_valid (and not stalled): x_flush=1, because the FD instruction is wrong-path. pc_en=1 so the PC takes the redirect target.
  - If halt_req and not stalling: pc_en=0, fd_en=0, x_flush=1. Go to DRAIN.
  - Priority: mem stall > redirect > halt. A redirect under stall is acted on in the cycle the stall clears.
- MEM_WAIT:
  - dmem_req=1 is held; X contents frozen; same enables as the stall cycle.
  - On dmem_gnt: the stall cycle ends with RUN-style enables, including the redirect rule. Go to RUN, clear the wait counter.
  - Otherwise, increment the wait counter. When it reaches TIMEOUT without grant -> ERR.
- DRAIN:
  - pc_en=fd_en=0; x_flush=1; x_en=mw_en=1; the dmem handshake applies as in RUN, and a stall pauses the drain.
  - When !x_valid & !mw_valid -> HALT.
- HALT:
  - All enables 0; halted=1 (registered on entry).
  - When halt_req falls -> RUN next cycle; halted drops with state exit.
  - Redirects are ignored because X is empty.
- ERR:
  - All enables 0, flushes 1, dmem_req=0, err=1.
  - Only rst_n exits.
- stall_cnt increments every cycle spent in MEM_WAIT or in the initial stall cycle (dmem_req & !dmem_gnt). It saturates at all-ones and does not wrap.
- dmem_req never asserts while x_valid=0, nor in BOOT/HALT/ERR.
- Reset mid-MEM_WAIT drops dmem_req asynchronously. The memory side must tolerate a withdrawn request.

Decomposition:
- Shared package core_ctrl_pkg: state enum (BOOT, RUN, MEM_WAIT, DRAIN, HALT, ERR) and default constants BOOT_CYCLES_DEF, TIMEOUT_DEF.
- One natural sub-module: sat_counter (parameter width; inc and clear inputs), used for stall_cnt.

Test Plan:
- Release rst_n with BOOT_CYCLES=4 -> enables low and flushes high for 4 cycles; 5th cycle pc_en=1, boot_done=1.
- RUN, store in X (x_valid=1,x_mem=1), dmem_gnt low 3 cycles then high -> dmem_req high 4 cycles, pc/fd/x_en low 3 cycles, mw_flush 3 cycles, stall_cnt=3.
- x_redirect=1 in RUN with dmem idle -> same cycle x_flush=1, pc_en=1; next cycle no flush.
- Redirect coincident with ungranted mem op, grant after 2 cycles -> x_flush only on the grant cycle.
- halt_req=1 with X and MW valid, valids drop over 2 cycles -> pc_en=0 immediately, halted=1 after drain; halt_req low -> RUN, pc_en=1 next cycle.
- dmem_gnt held low with TIMEOUT=64 -> err=1 after 64 wait cycles, all enables 0, sticky until rst_n; stall_cnt at CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/pipe_sequencer_pkg.sv
// rtl/pipe_sequencer_pkg.sv - shared sequencer states and default parameters
// Contents: state_e (sequencer states), BOOT_CYCLES_DEF, TIMEOUT_DEF, CNT_W_DEF.
package core_ctrl_pkg;

  localparam int BOOT_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF     = 64;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALT     = 3'd4,
    ST_ERR      = 3'd5
  } state_e;

endpackage

// File: rtl/pipe_sequencer_if.sv
// rtl/pipe_sequencer_if.sv - pipeline status in, stage controls and dmem handshake out
// master: sequencer side (status/grant/halt_req in; enables, flushes, dmem_req, status out)
// slave : pipeline side (mirror image of master)
interface pipe_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             x_valid;
  logic             x_mem;
  logic             x_redirect;
  logic             mw_valid;
  logic             dmem_gnt;
  logic             halt_req;
  logic             pc_en;
  logic             fd_en;
  logic             x_en;
  logic             mw_en;
  logic             x_flush;
  logic             mw_flush;
  logic             dmem_req;
  logic             boot_done;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  x_valid, x_mem, x_redirect, mw_valid, dmem_gnt, halt_req,
    output pc_en, fd_en, x_en, mw_en, x_flush, mw_flush, dmem_req,
    output boot_done, halted, err, stall_cnt
  );

  modport slave (
    output x_valid, x_mem, x_redirect, mw_valid, dmem_gnt, halt_req,
    input  pc_en, fd_en, x_en, mw_en, x_flush, mw_flush, dmem_req,
    input  boot_done, halted, err, stall_cnt
  );
endinterface

// File: rtl/pipe_sequencer_sat_counter.sv
// rtl/pipe_sequencer_sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst_n (async active-low), inc_i (count this cycle), clr_i (clear, wins over inc),
//        cnt_o (current count, holds at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - 3-stage pipeline sequencer: boot, dmem stall, redirect, halt/drain, timeout
// Ports: clk, rst_n (async active-low); bus (pipe_sequencer_if.master) carrying stage status in,
//        stage enables/flushes, dmem_req/dmem_gnt, boot_done, halted, err and stall_cnt.
module pipe_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_sequencer_if.master  bus
);
  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);
  // The stall cycle that enters MEM_WAIT already counts as wait cycle 1.
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   boot_q, boot_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            boot_done_q, boot_done_d;
  // Remembers that a stall interrupted a drain, so the grant resumes draining.
  logic            drain_q, drain_d;

  logic            pc_en, fd_en, x_en, mw_en, x_flush, mw_flush, dmem_req, stall;
  logic [CNT_W-1:0] stall_cnt;

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    wait_d      = wait_q;
    boot_done_d = boot_done_q;
    drain_d     = drain_q;
    pc_en       = 1'b0;
    fd_en       = 1'b0;
    x_en        = 1'b0;
    mw_en       = 1'b0;
    x_flush     = 1'b1;
    mw_flush    = 1'b1;
    dmem_req    = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_q == '0) begin
          state_d     = ST_RUN;
          boot_done_d = 1'b1;
        end else begin
          boot_d = boot_q - 1'b1;
        end
      end
      ST_RUN, ST_DRAIN, ST_MEM_WAIT: begin
        dmem_req = bus.x_valid & bus.x_mem;
        stall    = dmem_req & ~bus.dmem_gnt;
        if (stall) begin
          // Freeze front end and X, push a bubble into MW.
          mw_en   = 1'b1;
          x_flush = 1'b0;
          if (state_q == ST_MEM_WAIT) begin
            wait_d = wait_q + 1'b1;
            if (wait_q == WAIT_LAST) begin
              state_d = ST_ERR;
            end
          end else begin
            state_d = ST_MEM_WAIT;
            wait_d  = WW'(1);
            drain_d = (state_q == ST_DRAIN);
          end
        end else begin
          wait_d   = '0;
          pc_en    = 1'b1;
          fd_en    = 1'b1;
          x_en     = 1'b1;
          mw_en    = 1'b1;
          x_flush  = 1'b0;
          mw_flush = 1'b0;
          if ((state_q == ST_DRAIN) || ((state_q == ST_MEM_WAIT) && drain_q)) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            x_flush = 1'b1;
            state_d = (!bus.x_valid && !bus.mw_valid) ? ST_HALT : ST_DRAIN;
          end else if (bus.x_redirect && bus.x_valid) begin
            // FD holds a wrong-path instruction; PC takes the target.
            x_flush = 1'b1;
            state_d = ST_RUN;
          end else if (bus.halt_req) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            x_flush = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        x_flush  = 1'b0;
        mw_flush = 1'b0;
        if (!bus.halt_req) begin
          state_d = ST_RUN;
        end
      end
      ST_ERR: begin
      end
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      boot_q      <= BOOT_INIT;
      wait_q      <= '0;
      boot_done_q <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      wait_q      <= wait_d;
      boot_done_q <= boot_done_d;
      drain_q     <= drain_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall),
    .clr_i (1'b0),
    .cnt_o (stall_cnt)
  );

  assign bus.pc_en     = pc_en;
  assign bus.fd_en     = fd_en;
  assign bus.x_en      = x_en;
  assign bus.mw_en     = mw_en;
  assign bus.x_flush   = x_flush;
  assign bus.mw_flush  = mw_flush;
  assign bus.dmem_req  = dmem_req;
  assign bus.boot_done = boot_done_q;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.err       = (state_q == ST_ERR);
  assign bus.stall_cnt = stall_cnt;
endmodule
